// File: rtl/blink_code_seq_pkg.sv
// Shared definitions for the status-LED blink-code sequencer: state encoding,
// default timing constants and counter-width helpers.
package blink_code_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_PAUSE = 2'd3
  } blink_state_t;

  // 100 ms tick at 50 MHz, matching the heartbeat blinker's clock-rate definition
  localparam int DEF_TICK_DIV    = 5000000;
  localparam int DEF_ON_TICKS    = 2;
  localparam int DEF_OFF_TICKS   = 3;
  localparam int DEF_PAUSE_TICKS = 15;
  localparam int DEF_CODE_W      = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Never returns zero, so a counter that only needs to hold 0 still gets a bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blink_code_seq_tick_gen.sv
// Free-running prescaler: one-clk tick every TICK_DIV clocks. Reusable by any
// slow-rate block on the board.
module tick_gen
  import blink_code_seq_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/blink_code_seq.sv
// Status-LED output stage: passes the heartbeat through when idle, otherwise
// blinks a non-zero fault code as N short flashes followed by a long pause.
module blink_code_seq
  import blink_code_seq_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int PAUSE_TICKS = DEF_PAUSE_TICKS,
  parameter int CODE_W      = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              heartbeat,
  input  logic [CODE_W-1:0] code,
  output logic              led,
  output logic              busy
);

  localparam int PW = cnt_w(max3(ON_TICKS, OFF_TICKS, PAUSE_TICKS));
  localparam logic [PW-1:0] ON_LAST    = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_TICKS - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);

  blink_state_t      r_state, w_state_nx;
  logic [PW-1:0]     r_phase, w_phase_nx;
  logic [CODE_W-1:0] r_pulse, w_pulse_nx;
  logic [CODE_W-1:0] r_code,  w_code_nx;
  logic [CODE_W-1:0] w_pulse_inc;
  logic              r_led,   w_led_nx;
  logic              r_busy,  w_busy_nx;
  logic              w_tick;
  logic              w_code_nz;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_code_nz   = (code != '0);
  // Cannot overflow: the sequence leaves OFF as soon as this equals r_code
  assign w_pulse_inc = r_pulse + CODE_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_pulse_nx = r_pulse;
    w_code_nx  = r_code;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_code_nz) begin
            w_code_nx  = code;
            w_pulse_nx = '0;
            w_phase_nx = '0;
            w_state_nx = ST_ON;
          end
        end
        ST_ON: begin
          if (r_phase == ON_LAST) begin
            w_phase_nx = '0;
            w_state_nx = ST_OFF;
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
        ST_OFF: begin
          if (r_phase == OFF_LAST) begin
            w_phase_nx = '0;
            w_pulse_nx = w_pulse_inc;
            w_state_nx = (w_pulse_inc == r_code) ? ST_PAUSE : ST_ON;
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (r_phase == PAUSE_LAST) begin
            w_phase_nx = '0;
            if (w_code_nz) begin
              w_code_nx  = code;
              w_pulse_nx = '0;
              w_state_nx = ST_ON;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    // Pin drive is decoded from the next state so it moves on the same edge
    w_led_nx = 1'b0;
    case (w_state_nx)
      ST_IDLE: w_led_nx = heartbeat;
      ST_ON:   w_led_nx = 1'b1;
      default: w_led_nx = 1'b0;
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_pulse <= '0;
      r_code  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_pulse <= w_pulse_nx;
      r_code  <= w_code_nx;
      r_led   <= w_led_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign led  = r_led;
  assign busy = r_busy;

endmodule

// File: tb/tb_blink_code_seq.sv
// Bench for blink_code_seq: a timeline model predicts led/busy per clock into a
// queue; every falling edge pops one prediction and compares it with the pins.
module tb_blink_code_seq;

  localparam int TD      = 4;
  localparam int ON_T    = 2;
  localparam int OFF_T   = 3;
  localparam int PAUSE_T = 15;
  localparam int CW      = 4;
  localparam int ON_CLK  = ON_T * TD;            // 8
  localparam int FLASH   = (ON_T + OFF_T) * TD;  // 20
  localparam int PAUSE_C = PAUSE_T * TD;         // 60

  typedef struct packed {
    logic led;
    logic busy;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          heartbeat;
  logic [CW-1:0] code;
  logic          led;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q[$];

  // Model state: edges since reset release, sequence position and latched code
  int m_ecnt;
  bit m_in_seq;
  int m_pos;
  int m_code;

  blink_code_seq #(
    .TICK_DIV(TD), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
    .PAUSE_TICKS(PAUSE_T), .CODE_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .heartbeat(heartbeat),
    .code(code), .led(led), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int seq_len(input int c);
    return c * FLASH + PAUSE_C;
  endfunction

  always @(posedge clk or posedge reset) begin
    int ec;
    int pos;
    int cd;
    bit ins;
    exp_t e;
    if (reset) begin
      m_ecnt   <= 0;
      m_in_seq <= 1'b0;
      m_pos    <= 0;
      m_code   <= 0;
      q.delete();
    end else begin
      ec  = m_ecnt + 1;
      ins = m_in_seq;
      pos = m_pos;
      cd  = m_code;
      if (ins) begin
        pos = pos + 1;
        if (pos == seq_len(cd)) begin
          if (code != 0) begin
            cd  = int'(code);
            pos = 0;
          end else begin
            ins = 1'b0;
          end
        end
      end else if ((ec % TD) == 0 && code != 0) begin
        ins = 1'b1;
        cd  = int'(code);
        pos = 0;
      end
      e.led  = ins ? ((pos / FLASH) < cd && (pos % FLASH) < ON_CLK) : heartbeat;
      e.busy = ins;
      q.push_back(e);
      m_ecnt   <= ec;
      m_in_seq <= ins;
      m_pos    <= pos;
      m_code   <= cd;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      assert (led === e.led) else begin
        n_fail++;
        $error("FAIL led t=%0t observed %b expected %b", $time, led, e.led);
      end
      n_tests++;
      assert (busy === e.busy) else begin
        n_fail++;
        $error("FAIL busy t=%0t observed %b expected %b", $time, busy, e.busy);
      end
    end
  end

  initial begin
    heartbeat = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      heartbeat = ~heartbeat;
    end
  end

  task automatic count_flashes(input int cycles, output int n);
    logic prev;
    prev = 1'b0;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led === 1'b1 && prev === 1'b0) n++;
      prev = led;
    end
  endtask

  task automatic check_reset_pins(input string tag);
    n_tests++;
    assert (led === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_led observed %b expected 0", tag, led);
    end
    n_tests++;
    assert (busy === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_busy observed %b expected 0", tag, busy);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s timeout observed no event expected event", tag);
  endtask

  initial begin
    int  nf;
    bit  ok;
    reset = 1'b1;
    code  = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_pins("reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle: heartbeat passthrough
    repeat (40) @(negedge clk);

    // code 3 held for two full periods
    code = 4'd3;
    repeat (2 * seq_len(3) + 8) @(negedge clk);

    // Change to 5 during the second flash of a code-3 sequence
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_in_seq && m_code == 3 && m_pos == 25) ok = 1'b1;
    end
    if (!ok) timeout("wait_flash2");
    code = 4'd5;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_in_seq && m_code == 5 && m_pos == 0) ok = 1'b1;
    end
    if (!ok) timeout("wait_code5");
    count_flashes(seq_len(5) - 1, nf);
    n_tests++;
    assert (nf == 5) else begin
      n_fail++;
      $error("FAIL flashes_code5 observed %0d expected 5", nf);
    end

    // Max code: 15 flashes, no wrap
    code = 4'd15;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (m_in_seq && m_code == 15 && m_pos == 0) ok = 1'b1;
    end
    if (!ok) timeout("wait_code15");
    count_flashes(seq_len(15) - 1, nf);
    n_tests++;
    assert (nf == 15) else begin
      n_fail++;
      $error("FAIL flashes_code15 observed %0d expected 15", nf);
    end

    // code 2, dropped to 0 during an OFF phase
    code = 4'd2;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (m_in_seq && m_code == 2 && m_pos == 12) ok = 1'b1;
    end
    if (!ok) timeout("wait_code2_off");
    code = 4'd0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    if (!ok) timeout("wait_idle");
    repeat (30) @(negedge clk);

    // Reset pulse during ON with code 3 held
    code = 4'd3;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (m_in_seq && m_code == 3 && m_pos == 23) ok = 1'b1;
    end
    if (!ok) timeout("wait_on");
    reset = 1'b1;
    #1 check_reset_pins("midseq_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (seq_len(3) + 20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
